// File: rtl/bt_corr_pkg.sv
// Shared types and sizing for the access-code correlator.
package bt_corr_pkg;

    localparam int unsigned SYNC_LEN = 64;
    localparam int unsigned CHUNK_W  = 16;
    localparam int unsigned NCHUNK   = SYNC_LEN / CHUNK_W;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CORR,
        HIT,
        DONE
    } corr_state_e;

endpackage

// File: rtl/popcnt16.sv
// Combinational population count of one correlation chunk.
module popcnt16
    import bt_corr_pkg::*;
(
    input  logic [CHUNK_W-1:0] din_i,
    output logic [4:0]         cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            cnt_o = cnt_o + 5'(din_i[i]);
        end
    end

endmodule

// File: rtl/syncword_correlator.sv
// Sliding-window sync word correlator: counts bit errors chunk by chunk between bit strobes and
// flags the first window within threshold, or a timeout when the search length runs out.
module syncword_correlator
    import bt_corr_pkg::*;
#(
    parameter int unsigned WIN_W = 12
) (
    input  logic                clk_6M,
    input  logic                rstz,
    input  logic                p_1us,
    input  logic                rxbit,
    input  logic                corr_window,
    input  logic                page,
    input  logic                inquiry,
    input  logic                conns,
    input  logic                ps,
    input  logic                mpr,
    input  logic                spr,
    input  logic                regi_inquiryDIAC,
    input  logic [SYNC_LEN-1:0] regi_syncword_CAC,
    input  logic [SYNC_LEN-1:0] regi_syncword_DAC,
    input  logic [SYNC_LEN-1:0] regi_syncword_DIAC,
    input  logic [SYNC_LEN-1:0] regi_syncword_GIAC,
    input  logic [5:0]          regi_corr_thresh,
    input  logic [WIN_W-1:0]    regi_search_us,
    output logic                rx_trailer_st_p,
    output logic                sync_found,
    output logic [6:0]          sync_errcnt,
    output logic                rx_search_timeout_p,
    output logic                corr_busy
);

    localparam logic [2:0] PH_LAST = 3'(NCHUNK);
    localparam logic [2:0] PH_CMP  = 3'(NCHUNK + 1);

    // Inquiry is the fall-through case of the word select and needs no explicit decode.
    logic unused_inquiry;
    assign unused_inquiry = inquiry;

    corr_state_e         state_q, state_d;
    logic                cw_q;
    logic [SYNC_LEN-1:0] sw_q, sw_d, sr_q, sr_d, sw_sel, diff;
    logic [6:0]          bitcnt_q, bitcnt_d, acc_q, acc_d, errcnt_q, errcnt_d;
    logic [WIN_W-1:0]    uscnt_q, uscnt_d, uscnt_inc;
    logic [2:0]          phase_q, phase_d;
    logic                found_q, found_d;
    logic                trailer_p, timeout_p;
    logic [1:0]          chunk_k;
    logic [CHUNK_W-1:0]  chunk;
    logic [4:0]          chunk_ones;
    logic                search_lim, fill_tmo, corr_tmo, hit, accumulating;

    always_comb begin
        if (conns) begin
            sw_sel = regi_syncword_CAC;
        end else if (page || ps || mpr || spr) begin
            sw_sel = regi_syncword_DAC;
        end else if (regi_inquiryDIAC) begin
            sw_sel = regi_syncword_DIAC;
        end else begin
            sw_sel = regi_syncword_GIAC;
        end
    end

    // phase 1..NCHUNK adds chunk phase-1; phase NCHUNK+1 is the compare cycle.
    assign diff         = sr_q ^ sw_q;
    assign chunk_k      = 2'(phase_q - 3'd1);
    assign chunk        = diff[int'(chunk_k) * CHUNK_W +: CHUNK_W];
    assign accumulating = (phase_q != 3'd0) && (phase_q <= PH_LAST);

    popcnt16 u_popcnt (
        .din_i (chunk),
        .cnt_o (chunk_ones)
    );

    assign uscnt_inc  = uscnt_q + WIN_W'(1);
    assign search_lim = (regi_search_us != '0);
    assign fill_tmo   = search_lim && (uscnt_inc == regi_search_us);
    assign corr_tmo   = search_lim && (uscnt_q == regi_search_us);
    assign hit        = (acc_q <= {1'b0, regi_corr_thresh});

    always_comb begin
        state_d   = state_q;
        sw_d      = sw_q;
        sr_d      = sr_q;
        bitcnt_d  = bitcnt_q;
        uscnt_d   = uscnt_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        errcnt_d  = errcnt_q;
        found_d   = found_q;
        trailer_p = 1'b0;
        timeout_p = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (corr_window && !cw_q) begin
                    state_d  = FILL;
                    sw_d     = sw_sel;
                    sr_d     = '0;
                    bitcnt_d = '0;
                    uscnt_d  = '0;
                    phase_d  = '0;
                    acc_d    = '0;
                    errcnt_d = '0;
                end
            end
            FILL: begin
                if (p_1us) begin
                    sr_d     = {sr_q[SYNC_LEN-2:0], rxbit};
                    bitcnt_d = bitcnt_q + 7'd1;
                    uscnt_d  = uscnt_inc;
                    // A timeout on the filling strobe is left to that strobe's compare.
                    if (bitcnt_q == 7'(SYNC_LEN - 1)) begin
                        state_d = CORR;
                        phase_d = 3'd1;
                        acc_d   = '0;
                    end else if (fill_tmo) begin
                        timeout_p = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            CORR: begin
                if (p_1us) begin
                    sr_d    = {sr_q[SYNC_LEN-2:0], rxbit};
                    uscnt_d = uscnt_inc;
                    phase_d = 3'd1;
                    acc_d   = '0;
                end else if (accumulating) begin
                    acc_d   = acc_q + {2'b00, chunk_ones};
                    phase_d = phase_q + 3'd1;
                end else if (phase_q == PH_CMP) begin
                    phase_d = '0;
                    if (hit) begin
                        state_d  = HIT;
                        errcnt_d = acc_q;
                    end else if (corr_tmo) begin
                        timeout_p = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            HIT: begin
                if (p_1us) begin
                    trailer_p = 1'b1;
                    found_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase

        if (!corr_window) begin
            state_d   = IDLE;
            found_d   = 1'b0;
            phase_d   = '0;
            trailer_p = 1'b0;
            timeout_p = 1'b0;
        end
    end

    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            state_q  <= IDLE;
            cw_q     <= 1'b0;
            sw_q     <= '0;
            sr_q     <= '0;
            bitcnt_q <= '0;
            uscnt_q  <= '0;
            phase_q  <= '0;
            acc_q    <= '0;
            errcnt_q <= '0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cw_q     <= corr_window;
            sw_q     <= sw_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            uscnt_q  <= uscnt_d;
            phase_q  <= phase_d;
            acc_q    <= acc_d;
            errcnt_q <= errcnt_d;
            found_q  <= found_d;
        end
    end

    // The pulses are combinational, so suppress them on a reset cycle.
    assign rx_trailer_st_p     = trailer_p & rstz;
    assign rx_search_timeout_p = timeout_p & rstz;
    assign sync_found          = found_q;
    assign sync_errcnt         = errcnt_q;
    assign corr_busy           = (state_q != IDLE);

endmodule
